// File: rtl/rv_io_if.sv
// rv_io_if: memory-mapped IO bus between the RV32I core (master) and the board wrapper (slave).
interface rv_io_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    modport master(output req, we, addr, be, wdata, input rdata, ack);
    modport slave(input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/rv_board_wrapper.sv
// rv_board_wrapper: board top for the RV32I core; the core attaches through io and is reset by core_rst.
// Provides reset conditioning, switch sync, IO register decode and a scan-multiplexed active-low 7-seg display.
module rv_board_wrapper #(
    parameter logic [31:0] IO_BASE  = 32'h8000_0000,
    parameter int          SCAN_DIV = 100_000
) (
    input  logic        clk_100_in,
    input  logic        ext_rst_in,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic [6:0]  sseg_out,
    output logic        dp_out,
    output logic [7:0]  an_out,
    output logic        core_rst,
    rv_io_if.slave      io
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [1:0]    rst_sync;
    logic          rst;
    logic [15:0]   sw_s1, sw_s2;
    logic [31:0]   digits;
    logic [15:0]   ctrl;
    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [1:0]    sel;
    logic          hit, wr;
    logic [31:0]   rd_val, wmerge;
    logic          unused_addr;

    function automatic logic [6:0] hex7seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Asserts immediately, releases two edges after ext_rst_in falls.
    always_ff @(posedge clk_100_in or posedge ext_rst_in)
        if (ext_rst_in) rst_sync <= 2'b11;
        else            rst_sync <= {rst_sync[0], 1'b0};

    assign rst         = rst_sync[1];
    assign core_rst    = rst;
    assign sel         = io.addr[3:2];
    assign hit         = io.addr[31:4] == IO_BASE[31:4];
    assign wr          = io.req & io.we & hit;
    assign unused_addr = &{1'b0, io.addr[1:0]};

    // Write data merges enabled byte lanes onto the register's current contents.
    always_comb begin
        rd_val = sel == 2'd0 ? {16'h0, led_out} :
                 sel == 2'd1 ? {16'h0, sw_s2}   :
                 sel == 2'd2 ? digits           : {16'h0, ctrl};
        wmerge = rd_val;
        for (int i = 0; i < 4; i++)
            if (io.be[i]) wmerge[8*i +: 8] = io.wdata[8*i +: 8];
    end

    always_ff @(posedge clk_100_in or posedge rst)
        if (rst) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            led_out  <= '0;
            digits   <= '0;
            ctrl     <= '0;
            presc    <= '0;
            idx      <= '0;
            io.ack   <= 1'b0;
            io.rdata <= '0;
            an_out   <= 8'hFF;
            sseg_out <= 7'h7F;
            dp_out   <= 1'b1;
        end else begin
            sw_s1    <= sw_in;
            sw_s2    <= sw_s1;
            io.ack   <= io.req;
            io.rdata <= (io.req & ~io.we & hit) ? rd_val : 32'h0;
            if (wr && sel == 2'd0) led_out <= wmerge[15:0];
            if (wr && sel == 2'd2) digits  <= wmerge;
            if (wr && sel == 2'd3) ctrl    <= wmerge[15:0];
            presc <= (presc == LAST) ? '0 : presc + 1'b1;
            if (presc == LAST) idx <= idx + 3'd1;
            // Latch a whole slot at its first cycle so anode and segments switch together.
            if (presc == '0) begin
                an_out   <= ~((8'd1 << idx) & ctrl[7:0]);
                sseg_out <= ~hex7seg(digits[{idx, 2'b00} +: 4]);
                dp_out   <= ~ctrl[{1'b1, idx}];
            end
        end
endmodule

// File: tb/tb_rv_board_wrapper.sv
// tb_rv_board_wrapper: directed and randomized bus traffic against a register/scan model; SCAN_DIV=4.
module tb_rv_board_wrapper;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        ext_rst = 1'b1;
    logic [15:0] sw = 16'h0;
    logic [15:0] led;
    logic [6:0]  sseg;
    logic        dp;
    logic [7:0]  an;
    logic        core_rst;

    rv_io_if bus();

    rv_board_wrapper #(.SCAN_DIV(SD)) dut (
        .clk_100_in(clk), .ext_rst_in(ext_rst), .sw_in(sw), .led_out(led),
        .sseg_out(sseg), .dp_out(dp), .an_out(an), .core_rst(core_rst), .io(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cnt = 0;
    int last_wr = 0;
    logic [15:0] m_led = 0, m_sw = 0, m_ctrl = 0;
    logic [31:0] m_dig = 0;
    logic [6:0] hex_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Edges elapsed since reset release: after edge n the display shows slot (n-1)/SD.
    always @(posedge clk) cnt <= core_rst ? 0 : cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (a[31:4] != 28'h800_0000) return 32'h0;
        case (a[3:2])
            2'd0: return {16'h0, m_led};
            2'd1: return {16'h0, m_sw};
            2'd2: return m_dig;
            default: return {16'h0, m_ctrl};
        endcase
    endfunction

    task automatic xfer(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input string tag);
        logic [31:0] exp, mask, nv;
        exp = we ? 32'h0 : mread(a);
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        nv = (mread(a) & ~mask) | (wd & mask);
        bus.req = 1'b1; bus.we = we; bus.addr = a; bus.be = be; bus.wdata = wd;
        @(posedge clk);
        if (we && a[31:4] == 28'h800_0000) begin
            if (a[3:2] == 2'd0) m_led = nv[15:0];
            if (a[3:2] == 2'd2) m_dig = nv;
            if (a[3:2] == 2'd3) m_ctrl = nv[15:0];
        end
        @(negedge clk);
        bus.req = 1'b0;
        if (we) last_wr = cnt;
        chk({tag, " ack"}, {31'h0, bus.ack}, 32'h1);
        chk({tag, " rdata"}, bus.rdata, exp);
    endtask

    task automatic run_scan(input int n, input string tag);
        int d;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (cnt >= 1 && ((cnt - 1) / SD) * SD + 1 > last_wr) begin
                d = ((cnt - 1) / SD) % 8;
                chk({tag, " an"}, {24'h0, an}, {24'h0, m_ctrl[d] ? ~(8'd1 << d) : 8'hFF});
                chk({tag, " sseg"}, {25'h0, sseg}, {25'h0, ~hex_t[m_dig[4*d +: 4]]});
                chk({tag, " dp"}, {31'h0, dp}, {31'h0, ~m_ctrl[8+d]});
            end
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, " led"}, {16'h0, led}, 32'h0);
        chk({tag, " an"}, {24'h0, an}, 32'hFF);
        chk({tag, " sseg"}, {25'h0, sseg}, 32'h7F);
        chk({tag, " dp"}, {31'h0, dp}, 32'h1);
    endtask

    initial begin
        logic [31:0] a;
        bus.req = 0; bus.we = 0; bus.addr = 0; bus.be = 0; bus.wdata = 0;
        // Held reset with toggling switches
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sw = 16'(k * 16'h1111 + 16'h00F0);
            chk_blank("hold_rst");
        end
        sw = 16'h0;
        repeat (3) @(negedge clk);
        ext_rst = 1'b0;
        @(negedge clk);
        chk("rel_edge1 core_rst", {31'h0, core_rst}, 32'h1);
        @(negedge clk);
        chk("rel_edge2 core_rst", {31'h0, core_rst}, 32'h0);
        chk("idle ack", {31'h0, bus.ack}, 32'h0);
        chk("idle rdata", bus.rdata, 32'h0);
        // LED byte-lane writes
        xfer(1, 32'h8000_0000, 4'b0011, 32'h0000_A5C3, "led_wr");
        xfer(0, 32'h8000_0000, 4'b1111, 32'h0, "led_rd");
        chk("led_out a5c3", {16'h0, led}, 32'h0000_A5C3);
        xfer(1, 32'h8000_0000, 4'b0001, 32'hFFFF_FF00, "led_wr2");
        chk("led_out a500", {16'h0, led}, 32'h0000_A500);
        xfer(1, 32'h8000_0000, 4'b1100, 32'hFFFF_FFFF, "led_hi");
        xfer(0, 32'h8000_0000, 4'b1111, 32'h0, "led_hi_rd");
        // Switch synchroniser latency: two reads see the old value, the third the new one
        sw = 16'h1234;
        xfer(0, 32'h8000_0004, 4'b1111, 32'h0, "sw_lat0");
        xfer(0, 32'h8000_0004, 4'b1111, 32'h0, "sw_lat1");
        m_sw = 16'h1234;
        xfer(0, 32'h8000_0004, 4'b1111, 32'h0, "sw_lat2");
        xfer(1, 32'h8000_0004, 4'b1111, 32'hDEAD_BEEF, "sw_wr");
        xfer(0, 32'h8000_0004, 4'b1111, 32'h0, "sw_rd");
        // Display scan
        xfer(1, 32'h8000_0008, 4'b1111, 32'h7654_3210, "dig_wr");
        xfer(1, 32'h8000_000C, 4'b1111, 32'h0000_01FF, "ctrl_wr");
        run_scan(8 * SD * 2 + 4, "scan_all");
        xfer(1, 32'h8000_000C, 4'b1111, 32'h0000_0005, "ctrl_05");
        run_scan(8 * SD * 2 + 4, "scan_05");
        // Randomized bus traffic
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(3) == 0) begin
                sw = 16'($urandom);
                m_sw = sw;
                repeat (2) @(negedge clk);
            end
            a = ($urandom_range(7) == 0) ? $urandom : {28'h800_0000, 2'($urandom_range(3)), 2'($urandom_range(3))};
            xfer(1'($urandom_range(1)), a, 4'($urandom), $urandom, "rnd");
            chk("rnd led_out", {16'h0, led}, {16'h0, m_led});
        end
        xfer(1, 32'h8000_0008, 4'b1111, $urandom, "rnd_dig");
        xfer(1, 32'h8000_000C, 4'b0011, $urandom, "rnd_ctrl");
        run_scan(8 * SD * 2 + 4, "scan_rnd");
        // Out-of-window read, then reset during digit 3
        xfer(0, 32'h0000_1000, 4'b1111, 32'h0, "oow_rd");
        xfer(1, 32'h8000_000C, 4'b1111, 32'h0000_00FF, "ctrl_ff");
        for (int k = 0; k < 80 && !(cnt - 1 > last_wr + SD && ((cnt - 1) / SD) % 8 == 3); k++)
            @(negedge clk);
        chk("pre_rst an", {24'h0, an}, 32'h0000_00F7);
        #2 ext_rst = 1'b1;
        #1 chk_blank("async_rst");
        chk("async_rst core_rst", {31'h0, core_rst}, 32'h1);
        m_led = 0; m_dig = 0; m_ctrl = 0; last_wr = 0;
        repeat (3) @(negedge clk);
        ext_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2 core_rst", {31'h0, core_rst}, 32'h0);
        xfer(0, 32'h8000_0000, 4'b1111, 32'h0, "rst_led");
        xfer(0, 32'h8000_0008, 4'b1111, 32'h0, "rst_dig");
        xfer(0, 32'h8000_000C, 4'b1111, 32'h0, "rst_ctrl");
        xfer(1, 32'h8000_000C, 4'b1111, 32'h0000_0101, "ctrl_d0");
        xfer(1, 32'h8000_0008, 4'b1111, 32'h0000_00A7, "dig_d0");
        run_scan(8 * SD * 2 + 4, "scan_restart");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
